pulse_cpi_sequencer: RTL and testbench
======================================

// Module: pulse_cpi_sequencer
// PURPOSE
//  Sequences the IF-ROM -> DDC -> pulse compressor chain for one coherent processing interval (CPI).
//  Per pulse: flush the chain, stream the ROM addresses 0..NUM_SAMPLES-1 one per clk, then count
//  compressor outputs until OUT_SAMPLES are captured or a timeout expires.
//  Repeats for num_pulses pulses, then reports CPI completion. Sits between the control host and the datapath.
// PARAMETERS
//  ADDR_W        11     ROM address width
//  NUM_SAMPLES   1500   IF samples fed per pulse
//  OUT_SAMPLES   150    compressor outputs expected per pulse (DDC decimates by 10)
//  CLEAR_CYCLES  8      cycles chain_rst is held high before each pulse
//  GAP_CYCLES    16     idle cycles between pulses (PRT padding)
//  TIMEOUT       20000  maximum DRAIN cycles before the pulse is aborted
//  PCNT_W        8      pulse counter width
// PORTS
//  clk            in   1        system clock, 100 MHz
//  rst_n          in   1        asynchronous active-low reset
//  start          in   1        1-cycle CPI start request; ignored unless busy=0
//  abort          in   1        synchronous abort; returns to IDLE
//  num_pulses     in   PCNT_W   pulses per CPI, latched on start; 0 is treated as 1
//  rom_en         out  1        ROM enable, high only in FEED
//  rom_addr       out  ADDR_W   ROM sample address
//  chain_rst      out  1        active-high synchronous reset to the DDC and compressor
//  pc_valid       in   1        compressor data_valid_out
//  cap_valid      out  1        pc_valid qualified to the capture window
//  cap_idx        out  ADDR_W   index of the captured output within the pulse
//  pulse_idx      out  PCNT_W   current pulse number
//  busy           out  1        high in every state other than IDLE
//  pulse_done     out  1        1-cycle strobe at the end of each pulse
//  cpi_done       out  1        1-cycle strobe coincident with the last pulse_done
//  timeout_err    out  1        sticky; cleared by the next accepted start
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - all outputs 0, except chain_rst=1
//   - state=IDLE, all counters 0
//  All state, counters and outputs are registered.
//  FSM transitions:
//   - IDLE->CLEAR on start.
//   - CLEAR: chain_rst=1 for CLEAR_CYCLES, then ->FEED.
//   - FEED: rom_en=1, rom_addr increments by 1 per clk from 0 to NUM_SAMPLES-1, then ->DRAIN
//     (rom_addr holds its final value).
//   - DRAIN: ->GAP when cap_idx reaches OUT_SAMPLES, or when the cycle count reaches TIMEOUT
//     (also sets timeout_err).
//   - GAP: GAP_CYCLES cycles, then either ->CLEAR with pulse_idx+1, or ->IDLE if it was the last pulse.
//  Capture window:
//   - Open from the first FEED cycle through DRAIN.
//   - cap_valid = pc_valid registered (1-cycle latency); cap_idx = count of prior cap_valid in the pulse.
//   - Captures beyond OUT_SAMPLES are suppressed.
//  Strobes:
//   - pulse_done pulses for one cycle on GAP entry.
//   - cpi_done is asserted in the same cycle as pulse_done for pulse num_pulses-1.
//  Boundary conditions:
//   - chain_rst: held 1 in IDLE and CLEAR, 0 elsewhere, so the chain never runs unsequenced.
//   - start while busy: ignored, no effect on counters.
//   - abort: the next state is IDLE from any state; no done strobes; timeout_err unchanged.
//     abort wins over start in the same cycle.
//   - pc_valid on the same cycle as the FEED->DRAIN transition: counted.
//   - pc_valid in CLEAR, GAP or IDLE: ignored.
//   - Timeout and the final capture in the same cycle: the capture wins; timeout_err is not set.
//   - rst_n asserted mid-pulse: immediate return to reset values; chain_rst=1 at once.
// STRUCTURE
//  Shared package pcomp_pkg:
//   - seq_state_t enum {IDLE, CLEAR, FEED, DRAIN, GAP}
//   - ADDR_W, NUM_SAMPLES, OUT_SAMPLES defaults, shared with the DDC and pulse compressor benches.
//  Sub-module: seq_down_counter (loadable down-counter with a zero flag), reused for the CLEAR, GAP
//  and TIMEOUT intervals. Everything else stays flat.
// TESTING
//  1. Single pulse:
//     - stimulus: num_pulses=1, start, ideal pc_valid every 10th cycle.
//     - required: rom_addr 0..1499 with rom_en high for exactly 1500 cycles; 150 cap_valid;
//       cap_idx 0..149; pulse_done and cpi_done together; busy falls after GAP.
//  2. CPI of 4 pulses:
//     - required: pulse_idx 0..3; four pulse_done strobes; cpi_done only with the 4th;
//       chain_rst high for 8 cycles before each FEED.
//  3. Starvation:
//     - stimulus: pc_valid held 0.
//     - required: DRAIN lasts exactly 20000 cycles; timeout_err=1; pulse_done still fires.
//     - follow-up: the next start clears timeout_err.
//  4. Abort:
//     - stimulus: abort at FEED address 700.
//     - required: IDLE next cycle; rom_en=0, chain_rst=1; no pulse_done.
//     - follow-up: a new start restarts from pulse_idx=0, rom_addr=0.
//  5. Reset and stray inputs:
//     - stimulus: rst_n low mid-DRAIN; pc_valid pulses while IDLE; start while busy.
//     - required: reset values are restored asynchronously; no cap_valid from the stray pc_valid;
//       the stray start is ignored.
//  6. Zero and overflow:
//     - stimulus 1: num_pulses=0 -> behaves as 1 pulse.
//     - stimulus 2: 160 pc_valid in one pulse -> only 150 cap_valid, and DRAIN exits at the 150th.

Source files
------------

// File: rtl/pcomp_pkg.sv
// Types and default sizes shared by the pulse-compression chain: sequencer, DDC and compressor.
package pcomp_pkg;

   localparam int ADDR_W      = 11;
   localparam int NUM_SAMPLES = 1500;
   localparam int OUT_SAMPLES = 150;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      GAP
   } seq_state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero; one instance times the CLEAR, GAP and DRAIN-timeout intervals.
module seq_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/pulse_cpi_sequencer.sv
// Sequences one CPI through the IF-ROM -> DDC -> pulse compressor chain:
// per pulse flush, stream the ROM, collect compressor outputs, then pad the PRT.
module pulse_cpi_sequencer #(
   parameter int ADDR_W       = pcomp_pkg::ADDR_W,
   parameter int NUM_SAMPLES  = pcomp_pkg::NUM_SAMPLES,
   parameter int OUT_SAMPLES  = pcomp_pkg::OUT_SAMPLES,
   parameter int CLEAR_CYCLES = 8,
   parameter int GAP_CYCLES   = 16,
   parameter int TIMEOUT      = 20000,
   parameter int PCNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [PCNT_W-1:0] num_pulses_i,
   output logic              rom_en_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              chain_rst_o,
   input  logic              pc_valid_i,
   output logic              cap_valid_o,
   output logic [ADDR_W-1:0] cap_idx_o,
   output logic [PCNT_W-1:0] pulse_idx_o,
   output logic              busy_o,
   output logic              pulse_done_o,
   output logic              cpi_done_o,
   output logic              timeout_err_o
);
   import pcomp_pkg::*;

   localparam int TMR_W = $clog2(TIMEOUT + CLEAR_CYCLES + GAP_CYCLES);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
   localparam logic [ADDR_W-1:0] OUT_LAST  = ADDR_W'(OUT_SAMPLES - 1);
   localparam logic [ADDR_W-1:0] OUT_FULL  = ADDR_W'(OUT_SAMPLES);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] cap_cnt_q, cap_cnt_d;
   logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
   logic [PCNT_W-1:0] pulse_idx_q, pulse_idx_d;
   logic [PCNT_W-1:0] last_q, last_d;
   logic              cap_valid_q, cap_valid_d;
   logic              rom_en_q, rom_en_d;
   logic              chain_rst_q, chain_rst_d;
   logic              busy_q, busy_d;
   logic              pulse_done_q, pulse_done_d;
   logic              cpi_done_q, cpi_done_d;
   logic              timeout_err_q, timeout_err_d;

   logic              tmr_load, tmr_zero;
   logic [TMR_W-1:0]  tmr_val;
   logic              accept, cap_full, start_ok, timed_out;

   seq_down_counter #(.W(TMR_W)) u_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      accept    = pc_valid_i && !abort_i && (state_q == FEED || state_q == DRAIN)
                  && (cap_cnt_q < OUT_FULL);
      // The final capture is judged in the same cycle as the timer so it can beat the timeout.
      cap_full  = (cap_cnt_q == OUT_FULL) || (accept && cap_cnt_q == OUT_LAST);
      start_ok  = start_i && !abort_i && (state_q == IDLE);
      timed_out = 1'b0;
      state_d   = state_q;

      case (state_q)
         IDLE:  if (start_i) state_d = CLEAR;
         CLEAR: if (tmr_zero) state_d = FEED;
         FEED:  if (rom_addr_q == LAST_ADDR) state_d = DRAIN;
         DRAIN: begin
            if (cap_full) begin
               state_d = GAP;
            end else if (tmr_zero) begin
               state_d   = GAP;
               timed_out = 1'b1;
            end
         end
         GAP:   if (tmr_zero) state_d = (pulse_idx_q == last_q) ? IDLE : CLEAR;
         default: state_d = IDLE;
      endcase

      if (abort_i) begin
         state_d   = IDLE;
         timed_out = 1'b0;
      end

      tmr_load = (state_d != state_q);
      tmr_val  = '0;
      case (state_d)
         CLEAR:   tmr_val = TMR_W'(CLEAR_CYCLES - 1);
         DRAIN:   tmr_val = TMR_W'(TIMEOUT - 1);
         GAP:     tmr_val = TMR_W'(GAP_CYCLES - 1);
         default: tmr_val = '0;
      endcase

      rom_addr_d = rom_addr_q;
      if (state_d == FEED) begin
         rom_addr_d = (state_q == FEED) ? rom_addr_q + 1'b1 : '0;
      end else if (state_d == IDLE || state_d == CLEAR) begin
         rom_addr_d = '0;
      end

      cap_valid_d = accept;
      cap_cnt_d   = cap_cnt_q;
      cap_idx_d   = cap_idx_q;
      if (accept) begin
         cap_idx_d = cap_cnt_q;
         cap_cnt_d = cap_cnt_q + 1'b1;
      end
      if (state_d == CLEAR && state_q != CLEAR) begin
         cap_cnt_d = '0;
         cap_idx_d = '0;
      end

      pulse_idx_d = pulse_idx_q;
      last_d      = last_q;
      if (start_ok) begin
         pulse_idx_d = '0;
         last_d      = (num_pulses_i == '0) ? '0 : num_pulses_i - 1'b1;
      end else if (state_q == GAP && state_d == CLEAR) begin
         pulse_idx_d = pulse_idx_q + 1'b1;
      end

      pulse_done_d  = (state_q == DRAIN) && (state_d == GAP);
      cpi_done_d    = pulse_done_d && (pulse_idx_q == last_q);
      timeout_err_d = start_ok ? 1'b0 : (timeout_err_q | timed_out);
      busy_d        = (state_d != IDLE);
      chain_rst_d   = (state_d == IDLE) || (state_d == CLEAR);
      rom_en_d      = (state_d == FEED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rom_addr_q    <= '0;
         cap_cnt_q     <= '0;
         cap_idx_q     <= '0;
         cap_valid_q   <= 1'b0;
         pulse_idx_q   <= '0;
         last_q        <= '0;
         rom_en_q      <= 1'b0;
         chain_rst_q   <= 1'b1;
         busy_q        <= 1'b0;
         pulse_done_q  <= 1'b0;
         cpi_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rom_addr_q    <= rom_addr_d;
         cap_cnt_q     <= cap_cnt_d;
         cap_idx_q     <= cap_idx_d;
         cap_valid_q   <= cap_valid_d;
         pulse_idx_q   <= pulse_idx_d;
         last_q        <= last_d;
         rom_en_q      <= rom_en_d;
         chain_rst_q   <= chain_rst_d;
         busy_q        <= busy_d;
         pulse_done_q  <= pulse_done_d;
         cpi_done_q    <= cpi_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign rom_en_o      = rom_en_q;
   assign rom_addr_o    = rom_addr_q;
   assign chain_rst_o   = chain_rst_q;
   assign cap_valid_o   = cap_valid_q;
   assign cap_idx_o     = cap_idx_q;
   assign pulse_idx_o   = pulse_idx_q;
   assign busy_o        = busy_q;
   assign pulse_done_o  = pulse_done_q;
   assign cpi_done_o    = cpi_done_q;
   assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_pulse_cpi_sequencer.sv
// Directed bench for pulse_cpi_sequencer: drives whole CPIs cycle by cycle and checks per-pulse tallies.
module tb_pulse_cpi_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic        pc_valid_i = 1'b0;
   logic [7:0]  num_pulses_i = 8'd0;
   logic        rom_en_o, chain_rst_o, cap_valid_o, busy_o;
   logic        pulse_done_o, cpi_done_o, timeout_err_o;
   logic [10:0] rom_addr_o, cap_idx_o;
   logic [7:0]  pulse_idx_o;

   always #5 clk = ~clk;

   pulse_cpi_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .num_pulses_i  (num_pulses_i),
      .rom_en_o      (rom_en_o),
      .rom_addr_o    (rom_addr_o),
      .chain_rst_o   (chain_rst_o),
      .pc_valid_i    (pc_valid_i),
      .cap_valid_o   (cap_valid_o),
      .cap_idx_o     (cap_idx_o),
      .pulse_idx_o   (pulse_idx_o),
      .busy_o        (busy_o),
      .pulse_done_o  (pulse_done_o),
      .cpi_done_o    (cpi_done_o),
      .timeout_err_o (timeout_err_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // per-run tallies gathered by step()
   int feed_cyc, addr_err, exp_addr, caps, capidx_err, cap_in_pulse;
   int pd_cnt, cpi_cnt, cpi_bad, pidx_err, drain_ctr, drain_bad, exp_drain;
   int clr_run, clr_bad, feeds, gap_ctr, c, sent;
   int d_p, per_p, n_p, stray_c, last_p;
   bit in_drain, c_on, prev_rom_en, pc_force;

   task automatic clear_stats();
      feed_cyc = 0; addr_err = 0; exp_addr = 0; caps = 0; capidx_err = 0; cap_in_pulse = 0;
      pd_cnt = 0; cpi_cnt = 0; cpi_bad = 0; pidx_err = 0; drain_ctr = 0; drain_bad = 0;
      clr_run = 0; clr_bad = 0; feeds = 0; gap_ctr = 0; c = 0; sent = 0;
      d_p = 0; per_p = 1; n_p = 0; stray_c = -1; last_p = 0; exp_drain = 0;
      in_drain = 0; c_on = 0; prev_rom_en = 0; pc_force = 0;
   endtask

   // One clock: observe on the falling edge, then drive inputs for the next rising edge.
   task automatic step();
      bit g;
      @(negedge clk);
      if (rom_en_o && !prev_rom_en) begin
         if (clr_run != 8) clr_bad++;
         feeds++; exp_addr = 0; c = 0; c_on = 1; sent = 0; cap_in_pulse = 0;
      end else if (c_on) begin
         c++;
      end
      clr_run = chain_rst_o ? clr_run + 1 : 0;
      if (rom_en_o) begin
         feed_cyc++;
         if (int'(rom_addr_o) != exp_addr) addr_err++;
         exp_addr++;
      end
      if (cap_valid_o) begin
         if (int'(cap_idx_o) != cap_in_pulse) capidx_err++;
         cap_in_pulse++; caps++;
      end
      if (cpi_done_o) begin
         cpi_cnt++;
         if (!pulse_done_o || int'(pulse_idx_o) != last_p) cpi_bad++;
      end
      if (pulse_done_o) begin
         if (int'(pulse_idx_o) != pd_cnt) pidx_err++;
         if (drain_ctr != exp_drain) drain_bad++;
         pd_cnt++; in_drain = 0; gap_ctr = 0;
      end else begin
         if (in_drain) drain_ctr++;
         gap_ctr++;
      end
      if (prev_rom_en && !rom_en_o && !pulse_done_o) begin
         in_drain = 1; drain_ctr = 1;
      end
      prev_rom_en = rom_en_o;
      g = c_on && c >= d_p && ((c - d_p) % per_p) == 0 && sent < n_p;
      if (g) sent++;
      pc_valid_i = g | pc_force;
      start_i = (stray_c >= 0) && c_on && (c == stray_c);
      if (start_i) num_pulses_i = 8'd3;
   endtask

   task automatic run_cpi(input string tag, input int np, input int d, input int per,
                          input int n, input int stray, input int exp_caps,
                          input int exp_drn, input int exp_to);
      int  np_eff;
      bit  fell;
      clear_stats();
      np_eff = (np == 0) ? 1 : np;
      d_p = d; per_p = per; n_p = n; stray_c = stray;
      last_p = np_eff - 1; exp_drain = exp_drn;
      num_pulses_i = 8'(np);
      start_i = 1'b1;
      step();
      chk({tag, "_to_clr"}, int'(timeout_err_o), 0);
      chk({tag, "_busy"}, int'(busy_o), 1);
      fell = 0;
      for (int i = 0; i < np_eff * 23000 && !fell; i++) begin
         step();
         if (!busy_o) fell = 1;
      end
      chk({tag, "_busy_fall"}, int'(fell), 1);
      chk({tag, "_feed_cyc"}, feed_cyc, 1500 * np_eff);
      chk({tag, "_feeds"}, feeds, np_eff);
      chk({tag, "_addr_err"}, addr_err, 0);
      chk({tag, "_caps"}, caps, exp_caps * np_eff);
      chk({tag, "_capidx_err"}, capidx_err, 0);
      chk({tag, "_pulse_done"}, pd_cnt, np_eff);
      chk({tag, "_pulse_idx_err"}, pidx_err, 0);
      chk({tag, "_cpi_done"}, cpi_cnt, 1);
      chk({tag, "_cpi_bad"}, cpi_bad, 0);
      chk({tag, "_drain_bad"}, drain_bad, 0);
      chk({tag, "_clear_bad"}, clr_bad, 0);
      chk({tag, "_gap_len"}, gap_ctr, 16);
      chk({tag, "_timeout_err"}, int'(timeout_err_o), exp_to);
      chk({tag, "_idle_chain_rst"}, int'(chain_rst_o), 1);
      $display("run %s: pulses=%0d feed_cyc=%0d caps=%0d last_drain=%0d timeout_err=%0d",
               tag, pd_cnt, feed_cyc, caps, drain_ctr, timeout_err_o);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_rom_en"}, int'(rom_en_o), 0);
      chk({tag, "_rom_addr"}, int'(rom_addr_o), 0);
      chk({tag, "_chain_rst"}, int'(chain_rst_o), 1);
      chk({tag, "_busy"}, int'(busy_o), 0);
      chk({tag, "_cap_valid"}, int'(cap_valid_o), 0);
      chk({tag, "_pulse_done"}, int'(pulse_done_o), 0);
      chk({tag, "_timeout_err"}, int'(timeout_err_o), 0);
   endtask

   initial begin
      bit found;
      clear_stats();
      #3 rst_n = 1'b0;
      #4 check_reset_values("por");
      @(negedge clk);
      rst_n = 1'b1;

      run_cpi("single", 1, 25, 10, 150, -1, 150, 16, 0);
      run_cpi("cpi4", 4, 25, 10, 150, -1, 150, 16, 0);
      run_cpi("starve", 1, 0, 10, 0, -1, 0, 20000, 1);
      run_cpi("to_vs_cap", 1, 20009, 10, 150, -1, 150, 20000, 0);

      // abort in the middle of FEED
      clear_stats();
      d_p = 25; per_p = 10; n_p = 150; last_p = 1;
      num_pulses_i = 8'd2;
      start_i = 1'b1;
      step();
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
         step();
         if (rom_en_o && rom_addr_o == 11'd700) found = 1;
      end
      chk("abort_reach_700", int'(found), 1);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("abort_rom_en", int'(rom_en_o), 0);
      chk("abort_chain_rst", int'(chain_rst_o), 1);
      chk("abort_busy", int'(busy_o), 0);
      repeat (20) step();
      chk("abort_no_pulse_done", pd_cnt, 0);
      chk("abort_no_cpi_done", cpi_cnt, 0);
      $display("run abort: stopped at rom_addr 700, pulse_done=%0d", pd_cnt);
      run_cpi("restart", 1, 25, 10, 150, -1, 150, 16, 0);

      // asynchronous reset in the middle of DRAIN
      clear_stats();
      num_pulses_i = 8'd1;
      start_i = 1'b1;
      step();
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         step();
         if (in_drain && drain_ctr == 50) found = 1;
      end
      chk("rst_reach_drain", int'(found), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_values("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      $display("run mid_rst: reset asserted 50 cycles into DRAIN");

      // stray pc_valid while idle
      clear_stats();
      pc_force = 1'b1;
      repeat (6) step();
      pc_force = 1'b0;
      repeat (3) step();
      chk("stray_pc_caps", caps, 0);
      chk("stray_pc_busy", int'(busy_o), 0);
      $display("run stray_pc: caps=%0d", caps);

      run_cpi("stray_start", 1, 25, 10, 150, 100, 150, 16, 0);
      run_cpi("zero_ovf", 0, 5, 5, 160, -1, 150, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
